// File: rtl/sdr_tx_pkg.sv
// Shared encodings for the SDR transmit scheduler: grant sources, UDP port offsets and FSM states.
package sdr_tx_pkg;

   localparam logic [2:0] SRC_RESP = 3'd0;
   localparam logic [2:0] SRC_CC   = 3'd1;
   localparam logic [2:0] SRC_MIC  = 3'd2;
   localparam logic [2:0] SRC_WB   = 3'd3;
   localparam logic [2:0] SRC_DDC  = 3'd4;
   localparam logic [2:0] SRC_NONE = 3'd7;

   localparam logic [7:0] PORT_RESP     = 8'd0;
   localparam logic [7:0] PORT_CC       = 8'd1;
   localparam logic [7:0] PORT_MIC      = 8'd2;
   localparam logic [7:0] PORT_WB       = 8'd3;
   localparam logic [7:0] PORT_DDC_BASE = 8'd11;

   typedef enum logic [1:0] {StIdle, StBusy, StGap} tx_state_e;

   function automatic logic [7:0] port_of(input logic [2:0] src, input logic [2:0] ddc);
      logic [7:0] port;
      port = PORT_RESP;
      unique case (src)
         SRC_CC:  port = PORT_CC;
         SRC_MIC: port = PORT_MIC;
         SRC_WB:  port = PORT_WB;
         SRC_DDC: port = PORT_DDC_BASE + {5'd0, ddc};
         default: port = PORT_RESP;
      endcase
      return port;
   endfunction

endpackage

// File: rtl/ddc_rr_arbiter.sv
// Rotate-priority encoder: first requesting DDC at or after rr_ptr, wrapping modulo NR.
module ddc_rr_arbiter
   import sdr_tx_pkg::*;
#(
   parameter int unsigned NR = 4
) (
   input  logic [NR-1:0] ddc_req,
   input  logic [2:0]    rr_ptr,
   output logic          found,
   output logic [2:0]    index
);

   logic [7:0] req_ext;
   logic [2:0] idx;

   assign req_ext = 8'(ddc_req);

   always_comb begin
      found = 1'b0;
      index = 3'd0;
      idx   = 3'd0;
      for (int unsigned off = 0; off < NR; off++) begin
         idx = 3'((32'(rr_ptr) + off) % NR);
         if (!found && req_ext[idx]) begin
            found = 1'b1;
            index = idx;
         end
      end
   end

endmodule

// File: rtl/sdr_tx_scheduler.sv
// Single-grant arbiter for the UDP transmit path: fixed priority for control traffic,
// round-robin DDCs, wideband gated to round completion, starvation guard and watchdog.
module sdr_tx_scheduler
   import sdr_tx_pkg::*;
#(
   parameter int unsigned NR         = 4,
   parameter logic [15:0] STARVE_MAX = 16'd2000,
   parameter logic [19:0] TIMEOUT    = 20'd200000,
   parameter logic [3:0]  GAP_CYCLES = 4'd2
) (
   input  logic          tx_clock,
   input  logic          reset,
   input  logic          run,
   input  logic          resp_req,
   input  logic          cc_req,
   input  logic          mic_req,
   input  logic          wb_req,
   input  logic          wb_burst,
   input  logic [NR-1:0] ddc_req,
   input  logic          pkt_done,
   output logic          grant_valid,
   output logic [2:0]    grant_src,
   output logic [2:0]    grant_ddc,
   output logic [7:0]    port_ID,
   output logic          phy_idle,
   output logic          timeout_err
);

   tx_state_e   state_q;
   logic [2:0]  rr_ptr_q;
   logic        round_done_q;
   logic [15:0] starve_cnt_q;
   logic [19:0] timer_q;
   logic [3:0]  gap_cnt_q;

   logic       ddc_found;
   logic [2:0] ddc_idx;
   logic       win_valid;
   logic [2:0] win_src;
   logic [2:0] win_ddc;
   logic [2:0] rr_next;
   logic       ddc_active;
   logic       starved;

   ddc_rr_arbiter #(.NR(NR)) u_rr (
      .ddc_req (ddc_req),
      .rr_ptr  (rr_ptr_q),
      .found   (ddc_found),
      .index   (ddc_idx)
   );

   assign ddc_active = grant_valid && (grant_src == SRC_DDC);
   assign starved    = starve_cnt_q >= STARVE_MAX;
   assign phy_idle   = !ddc_active && (ddc_req == '0);
   assign rr_next    = (win_ddc == 3'(NR - 1)) ? 3'd0 : win_ddc + 3'd1;

   always_comb begin
      win_valid = 1'b0;
      win_src   = SRC_NONE;
      win_ddc   = 3'd0;
      if (resp_req) begin
         win_valid = 1'b1;
         win_src   = SRC_RESP;
      end else if (run) begin
         if (starved && ddc_found) begin
            win_valid = 1'b1;
            win_src   = SRC_DDC;
            win_ddc   = ddc_idx;
         end else if (cc_req) begin
            win_valid = 1'b1;
            win_src   = SRC_CC;
         end else if (mic_req) begin
            win_valid = 1'b1;
            win_src   = SRC_MIC;
         end else if (wb_req && (wb_burst || round_done_q)) begin
            win_valid = 1'b1;
            win_src   = SRC_WB;
         end else if (ddc_found) begin
            win_valid = 1'b1;
            win_src   = SRC_DDC;
            win_ddc   = ddc_idx;
         end else if (wb_req) begin
            // ddc_found low here means no DDC is requesting
            win_valid = 1'b1;
            win_src   = SRC_WB;
         end
      end
   end

   always_ff @(posedge tx_clock) begin
      if (reset) begin
         state_q      <= StIdle;
         grant_valid  <= 1'b0;
         grant_src    <= SRC_NONE;
         grant_ddc    <= 3'd0;
         port_ID      <= 8'd0;
         timeout_err  <= 1'b0;
         rr_ptr_q     <= 3'd0;
         round_done_q <= 1'b0;
         starve_cnt_q <= 16'd0;
         timer_q      <= 20'd0;
         gap_cnt_q    <= 4'd0;
      end else begin
         timeout_err <= 1'b0;
         if ((ddc_req == '0) || ddc_active) begin
            starve_cnt_q <= 16'd0;
         end else if (starve_cnt_q != 16'hffff) begin
            starve_cnt_q <= starve_cnt_q + 16'd1;
         end

         case (state_q)
            StIdle: begin
               if (!run) begin
                  rr_ptr_q     <= 3'd0;
                  round_done_q <= 1'b0;
                  starve_cnt_q <= 16'd0;
               end
               if (win_valid) begin
                  grant_valid <= 1'b1;
                  grant_src   <= win_src;
                  grant_ddc   <= win_ddc;
                  port_ID     <= port_of(win_src, win_ddc);
                  timer_q     <= 20'd0;
                  state_q     <= StBusy;
                  if (win_src == SRC_DDC) begin
                     starve_cnt_q <= 16'd0;
                     rr_ptr_q     <= rr_next;
                     if (rr_next == 3'd0) round_done_q <= 1'b1;
                  end
                  if (win_src == SRC_WB) round_done_q <= 1'b0;
               end
            end
            StBusy: begin
               if (pkt_done || (!run && grant_src != SRC_RESP)
                   || (timer_q == TIMEOUT - 20'd1)) begin
                  grant_valid <= 1'b0;
                  grant_src   <= SRC_NONE;
                  grant_ddc   <= 3'd0;
                  port_ID     <= 8'd0;
                  gap_cnt_q   <= 4'd0;
                  state_q     <= (GAP_CYCLES == 4'd0) ? StIdle : StGap;
                  // Watchdog pulse only when nothing else explains the release
                  timeout_err <= !pkt_done && !(!run && grant_src != SRC_RESP);
               end else begin
                  timer_q <= timer_q + 20'd1;
               end
            end
            StGap: begin
               if (gap_cnt_q >= GAP_CYCLES - 4'd1) state_q <= StIdle;
               else gap_cnt_q <= gap_cnt_q + 4'd1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sdr_tx_scheduler.sv
// Directed self-checking bench for sdr_tx_scheduler (NR=4, STARVE_MAX=50, TIMEOUT=100, GAP=2).
module tb_sdr_tx_scheduler;

   logic       tx_clock = 1'b0;
   logic       reset, run, resp_req, cc_req, mic_req, wb_req, wb_burst, pkt_done;
   logic [3:0] ddc_req;
   logic       grant_valid, phy_idle, timeout_err;
   logic [2:0] grant_src, grant_ddc;
   logic [7:0] port_ID;

   int checks   = 0;
   int failures = 0;

   sdr_tx_scheduler #(
      .NR         (4),
      .STARVE_MAX (16'd50),
      .TIMEOUT    (20'd100),
      .GAP_CYCLES (4'd2)
   ) dut (
      .tx_clock    (tx_clock),
      .reset       (reset),
      .run         (run),
      .resp_req    (resp_req),
      .cc_req      (cc_req),
      .mic_req     (mic_req),
      .wb_req      (wb_req),
      .wb_burst    (wb_burst),
      .ddc_req     (ddc_req),
      .pkt_done    (pkt_done),
      .grant_valid (grant_valid),
      .grant_src   (grant_src),
      .grant_ddc   (grant_ddc),
      .port_ID     (port_ID),
      .phy_idle    (phy_idle),
      .timeout_err (timeout_err)
   );

   always #5 tx_clock = ~tx_clock;

   task automatic step();
      @(posedge tx_clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(input string tag);
      int n;
      n = 0;
      while (!grant_valid && n < 60) begin
         step();
         n++;
      end
      check({tag, "_arrived"}, 32'(grant_valid), 32'd1);
   endtask

   task automatic finish_pkt();
      pkt_done = 1'b1;
      step();
      pkt_done = 1'b0;
   endtask

   task automatic expect_grant(input string tag, input logic [2:0] src, input logic [2:0] ddc,
                               input logic [7:0] port);
      wait_grant(tag);
      check({tag, "_src"}, 32'(grant_src), 32'(src));
      check({tag, "_ddc"}, 32'(grant_ddc), 32'(ddc));
      check({tag, "_port"}, 32'(port_ID), 32'(port));
   endtask

   initial begin
      int seen, cc_count, hi, errs;
      reset = 1'b1; run = 1'b0; resp_req = 1'b0; cc_req = 1'b0; mic_req = 1'b0;
      wb_req = 1'b0; wb_burst = 1'b0; ddc_req = 4'b0000; pkt_done = 1'b0;
      step();
      step();
      check("rst_valid", 32'(grant_valid), 32'd0);
      check("rst_src", 32'(grant_src), 32'd7);
      check("rst_ddc", 32'(grant_ddc), 32'd0);
      check("rst_port", 32'(port_ID), 32'd0);
      check("rst_terr", 32'(timeout_err), 32'd0);
      check("rst_phy_idle", 32'(phy_idle), 32'd1);

      // 1: cc beats mic beats DDCs; DDCs then go 0..3
      reset = 1'b0; run = 1'b1; cc_req = 1'b1; mic_req = 1'b1; ddc_req = 4'b1111;
      step();
      check("t1_latency", 32'(grant_valid), 32'd1);
      check("t1_cc_src", 32'(grant_src), 32'd1);
      check("t1_cc_port", 32'(port_ID), 32'd1);
      cc_req = 1'b0;
      finish_pkt();
      check("t1_release_valid", 32'(grant_valid), 32'd0);
      check("t1_release_src", 32'(grant_src), 32'd7);
      step();
      step();
      check("t1_gap_held", 32'(grant_valid), 32'd0);
      step();
      check("t1_mic_valid", 32'(grant_valid), 32'd1);
      check("t1_mic_src", 32'(grant_src), 32'd2);
      check("t1_mic_port", 32'(port_ID), 32'd2);
      mic_req = 1'b0;
      finish_pkt();
      for (int i = 0; i < 4; i++) begin
         expect_grant($sformatf("t1_ddc%0d", i), 3'd4, 3'(i), 8'(11 + i));
         check($sformatf("t1_ddc%0d_phy_idle", i), 32'(phy_idle), 32'd0);
         if (i == 3) ddc_req = 4'b0000;
         finish_pkt();
      end

      // 2: resp served with run low; cc is not
      run = 1'b0; resp_req = 1'b1;
      expect_grant("t2_resp", 3'd0, 3'd0, 8'd0);
      resp_req = 1'b0;
      finish_pkt();
      cc_req = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (grant_valid) seen++;
      end
      check("t2_no_grant_run_low", 32'(seen), 32'd0);

      // 3: starvation promotes DDC 2 above a continuously requesting cc
      run = 1'b1; ddc_req = 4'b0100;
      cc_count = 0;
      for (int i = 0; i < 20; i++) begin
         wait_grant("t3_grant");
         if (grant_src == 3'd4) break;
         if (grant_src == 3'd1) cc_count++;
         finish_pkt();
      end
      check("t3_starved_src", 32'(grant_src), 32'd4);
      check("t3_starved_ddc", 32'(grant_ddc), 32'd2);
      check("t3_starved_port", 32'(port_ID), 32'd13);
      check("t3_cc_before_promo", 32'(cc_count >= 10 && cc_count <= 14), 32'd1);
      cc_req = 1'b0; ddc_req = 4'b0000;
      finish_pkt();

      // 4: wb waits for round completion
      wb_req = 1'b1; wb_burst = 1'b0; ddc_req = 4'b0011;
      expect_grant("t4_ddc0", 3'd4, 3'd0, 8'd11);
      finish_pkt();
      expect_grant("t4_ddc1", 3'd4, 3'd1, 8'd12);
      ddc_req = 4'b1000;
      finish_pkt();
      expect_grant("t4_ddc3_wrap", 3'd4, 3'd3, 8'd14);
      finish_pkt();
      expect_grant("t4_wb", 3'd3, 3'd0, 8'd3);
      finish_pkt();
      expect_grant("t4_ddc3_after_wb", 3'd4, 3'd3, 8'd14);
      wb_req = 1'b0; ddc_req = 4'b0001;
      finish_pkt();

      // 5: watchdog releases after 100 cycles with one timeout_err pulse
      expect_grant("t5_ddc0", 3'd4, 3'd0, 8'd11);
      hi = 0; errs = 0;
      while (grant_valid && hi < 150) begin
         if (timeout_err) errs++;
         hi++;
         step();
      end
      if (timeout_err) errs++;
      ddc_req = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         step();
         if (timeout_err) errs++;
      end
      check("t5_grant_cycles", 32'(hi), 32'd100);
      check("t5_terr_pulses", 32'(errs), 32'd1);

      // 6: run drop releases a DDC grant and clears rr_ptr
      ddc_req = 4'b0010;
      expect_grant("t6_ddc1", 3'd4, 3'd1, 8'd12);
      run = 1'b0;
      step();
      check("t6_run_drop_valid", 32'(grant_valid), 32'd0);
      check("t6_run_drop_src", 32'(grant_src), 32'd7);
      check("t6_run_drop_terr", 32'(timeout_err), 32'd0);
      check("t6_phy_busy_req", 32'(phy_idle), 32'd0);
      ddc_req = 4'b0000;
      step();
      check("t6_phy_idle", 32'(phy_idle), 32'd1);
      for (int i = 0; i < 5; i++) step();
      run = 1'b1; ddc_req = 4'b1111;
      expect_grant("t6_rr_cleared", 3'd4, 3'd0, 8'd11);

      // Reset in mid-grant
      reset = 1'b1;
      step();
      check("rst_mid_valid", 32'(grant_valid), 32'd0);
      check("rst_mid_src", 32'(grant_src), 32'd7);
      check("rst_mid_port", 32'(port_ID), 32'd0);
      reset = 1'b0; ddc_req = 4'b0000; run = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdr_tx_scheduler.md
Name: sdr_tx_scheduler

Overview:
- Arbitrates the single UDP transmit path between all packet sources: discovery/programming responses, CC status, mic, wideband and NR DDC receivers.
- Sits between the per-stream "data ready" flags and the packet formatter. Issues exactly one grant at a time and holds it until the formatter reports the packet done.
- Provides fixed priority for control traffic, round-robin among DDCs, wideband gated to DDC round completion, a DDC starvation guard and a stuck-packet watchdog.

Parameters:
- NR, 4, number of DDC receivers (1..8).
- STARVE_MAX, 16'd2000, tx_clock cycles a DDC may wait before it is promoted above cc/mic/wb.
- TIMEOUT, 20'd200000, maximum grant duration in tx_clock cycles before forced release.
- GAP_CYCLES, 4'd2, idle cycles enforced between consecutive grants.

Ports:
- tx_clock  in  1  transmit clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  radio running; gates every source except resp_req.
- resp_req  in  1  discovery/erase/program reply pending (level).
- cc_req  in  1  CC status packet ready (level).
- mic_req  in  1  mic FIFO ready (level).
- wb_req  in  1  wideband data ready (level).
- wb_burst  in  1  wideband frame set in progress (more blocks owed).
- ddc_req  in  NR  per-DDC FIFO ready (level).
- pkt_done  in  1  one-cycle pulse: formatter finished the granted packet.
- grant_valid  out  1  a grant is active.
- grant_src  out  3  0 resp, 1 cc, 2 mic, 3 wb, 4 ddc; 7 none.
- grant_ddc  out  3  DDC index when grant_src==4, else 0.
- port_ID  out  8  from-port offset: resp 0, cc 1, mic 2, wb 3, ddc 11+index.
- phy_idle  out  1  high when no DDC grant is active and ddc_req==0.
- timeout_err  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset values: grant_valid 0, grant_src 7, grant_ddc 0, port_ID 0, timeout_err 0, rr_ptr 0, starve_cnt 0, round_done 0, state IDLE.
- State machine IDLE -> BUSY -> GAP -> IDLE.
- IDLE:
  - Evaluate eligible requests each cycle.
  - If any request is eligible, register the winner and assert grant_valid in the next cycle (latency 1 from request to grant). Go to BUSY.
- Priority, highest first:
  1. resp (eligible regardless of run).
  2. Starved DDC: starve_cnt >= STARVE_MAX, with run high.
  3. cc.
  4. mic.
  5. wb, only if wb_burst or round_done.
  6. DDC round-robin.
  7. wb with no DDC requesting.
- DDC round-robin:
  - Search starts at rr_ptr and wraps modulo NR.
  - On a DDC grant, rr_ptr <= winner+1 (mod NR).
  - round_done sets when rr_ptr wraps to 0 and clears on any wb grant.
- BUSY:
  - Outputs are held stable.
  - pkt_done -> drop grant_valid, grant_src=7, go to GAP.
  - Timer reaching TIMEOUT -> same release plus timeout_err pulse.
  - run falling while grant_src != 0 -> release next cycle with no timeout_err.
  - pkt_done while in IDLE or GAP is ignored.
- GAP: count GAP_CYCLES with no grant, then go to IDLE. GAP_CYCLES=0 means IDLE directly.
- starve_cnt:
  - Increments (saturating at 16 bits) each cycle that ddc_req!=0 and there is no DDC grant.
  - Clears on any DDC grant or when ddc_req==0.
- run low in IDLE: rr_ptr, round_done and starve_cnt are cleared; resp_req is still served.
- Simultaneous requests are resolved by priority in the same cycle. A request deasserting in the decision cycle is not granted.
- Reset in mid-grant returns all outputs to reset values on the next edge.

Decomposition:
- Shared package sdr_tx_pkg holds:
  - grant_src encodings SRC_RESP..SRC_DDC, SRC_NONE.
  - Port offset constants PORT_CC=1, PORT_MIC=2, PORT_WB=3, PORT_DDC_BASE=11.
  - State enum.
- One sub-module, ddc_rr_arbiter, takes ddc_req and rr_ptr and returns found and index (combinational rotate-priority encoder).

Test Plan:
1. Reset, then cc_req=1, mic_req=1, ddc_req=4'b1111 together -> grant_src=1, port_ID=1. After pkt_done and 2 gap cycles: mic (port 2), then DDC 0,1,2,3 in order (ports 11..14).
2. run=0, resp_req=1 -> grant_src=0, port_ID=0. With run=0 and cc_req=1, no grant is issued.
3. Hold cc_req=1, re-asserting it after each pkt_done, with ddc_req[2]=1 and STARVE_MAX=50 -> within about 50 cycles DDC 2 is granted ahead of cc.
4. wb_req=1, wb_burst=0, ddc_req=4'b0011 -> DDC 0 and DDC 1 are granted before wb. After round_done, wb is granted with port_ID=3.
5. Grant a DDC and withhold pkt_done for TIMEOUT cycles (set to 100) -> grant_valid drops at cycle 100 and timeout_err pulses exactly once.
6. During a DDC grant, drop run -> grant_valid=0 on the next edge, phy_idle=1 once ddc_req==0, rr_ptr reads 0.
